seg7_mux_driver: RTL and testbench

Time-multiplexed driver for a bank of common-cathode or common-anode 7-segment digits. It holds a multi-digit hex value, scans the digits one at a time at a programmable rate, and decodes each nibble to segments. It inserts anti-ghosting blank time and can suppress leading zeros. New values are committed only at frame boundaries, so a display never shows a torn value. It sits between the design's counter/datapath logic and the chip output pins.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_hex_lut.sv | 15 +
 rtl/seg7_mux_driver.sv | 190 +++++++++++++++++++
 tb/tb_seg7_mux_driver.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants for the 7-segment display driver:
//   - SEG_* bit positions inside a 7-bit segment vector (bit0 = a ... bit6 = g)
//   - SEG_BLANK, the pre-polarity "all segments off" pattern
//   - SEG_TABLE, hex nibble to segment pattern (pre-polarity, 1 = segment lit)
package seg7_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Entry n is the segment pattern for hex digit n; listed from F down to 0
   // because the packed concatenation fills the most significant entry first.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
      7'h7C, 7'h77, 7'h67, 7'h7F,   // b A 9 8
      7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
      7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
   };

endpackage

// File: rtl/seg7_hex_lut.sv
// seg7_hex_lut
// Purely combinational hex nibble to 7-segment lookup (active-high segments).
// Ports:
//   nibble_i    in  4  hex digit to display
//   segments_o  out 7  segment pattern, bit0 = a ... bit6 = g
module seg7_hex_lut
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] segments_o
);

   assign segments_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver
// Time-multiplexed driver for NUM_DIGITS 7-segment digits. Scans one digit per
// PRESCALE-cycle slot, blanks the first BLANK_CYCLES of each slot against
// ghosting, optionally suppresses leading zeros, and only swaps in a newly
// loaded value at a frame boundary so the display never tears. All outputs
// are registered (one cycle latency from the scan state).
// Ports:
//   clk          in   1             system clock
//   rst_n        in   1             synchronous active-low reset
//   enable       in   1             1 = scanning, 0 = outputs inactive, counters at 0
//   load         in   1             strobe capturing value/dp_in
//   value        in   4*NUM_DIGITS  hex digits, value[3:0] is digit 0
//   dp_in        in   NUM_DIGITS    decimal point per digit
//   lz_suppress  in   1             1 = blank leading zeros
//   segments     out  7             segment pins (bit0 = a ... bit6 = g)
//   dp_out       out  1             decimal point pin of the active digit
//   digit_en     out  NUM_DIGITS    one-hot digit select pins
//   frame_tick   out  1             pulse aligned with first blank cycle of digit 0
//   pending      out  1             a loaded value waits for the next frame boundary
module seg7_mux_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int PRESCALE       = 1000,
   parameter int BLANK_CYCLES   = 2,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lz_suppress,
   output logic [6:0]              segments,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    frame_tick,
   output logic                    pending
);

   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PCNT_W = $clog2(PRESCALE);

   localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(PRESCALE - 1);
   localparam logic [PCNT_W-1:0] PCNT_BLANK = PCNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   // Pin levels that mean "off" once polarity inversion is applied.
   localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

   logic [PCNT_W-1:0]       pcnt_q, pcnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shadowVal_q, shadowVal_d;
   logic [NUM_DIGITS-1:0]   shadowDp_q, shadowDp_d;
   logic                    pending_q, pending_d;
   logic [4*NUM_DIGITS-1:0] dispVal_q, dispVal_d;
   logic [NUM_DIGITS-1:0]   dispDp_q, dispDp_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   dig_q, dig_d;
   logic                    tick_q, tick_d;

   logic [NUM_DIGITS-1:0]   lzMask;
   logic                    blankRun;
   logic [3:0]              curNibble;
   logic [6:0]              lutSeg;
   logic                    lastPcnt;
   logic                    boundary;
   logic [6:0]              segPre;
   logic                    dpPre;
   logic [NUM_DIGITS-1:0]   digPre;

   // A digit is a leading zero while every digit above it is also a blanked
   // zero without a decimal point; the run starts at the top digit and stops
   // before digit 0, which is always shown.
   always_comb begin
      lzMask   = '0;
      blankRun = lz_suppress;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         blankRun  = blankRun && (dispVal_q[4*k +: 4] == 4'h0) && !dispDp_q[k];
         lzMask[k] = blankRun;
      end
   end

   assign curNibble = dispVal_q[4*idx_q +: 4];

   seg7_hex_lut uLut (
      .nibble_i   (curNibble),
      .segments_o (lutSeg)
   );

   // Scan counters, shadow/display commit, and the next pin values. A load on
   // the boundary cycle or while disabled bypasses the shadow stage, since
   // there is no frame in progress that it could tear.
   always_comb begin
      pcnt_d      = pcnt_q;
      idx_d       = idx_q;
      shadowVal_d = shadowVal_q;
      shadowDp_d  = shadowDp_q;
      pending_d   = pending_q;
      dispVal_d   = dispVal_q;
      dispDp_d    = dispDp_q;
      segPre      = SEG_BLANK;
      dpPre       = 1'b0;
      digPre      = '0;

      lastPcnt = (pcnt_q == PCNT_LAST);
      boundary = enable && lastPcnt && (idx_q == IDX_LAST);

      if (!enable) begin
         pcnt_d = '0;
         idx_d  = '0;
      end else if (lastPcnt) begin
         pcnt_d = '0;
         idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
         pcnt_d = pcnt_q + 1'b1;
      end

      if (boundary && pending_q) begin
         dispVal_d = shadowVal_q;
         dispDp_d  = shadowDp_q;
         pending_d = 1'b0;
      end

      if (load) begin
         shadowVal_d = value;
         shadowDp_d  = dp_in;
         if (!enable || boundary) begin
            dispVal_d = value;
            dispDp_d  = dp_in;
            pending_d = 1'b0;
         end else begin
            pending_d = 1'b1;
         end
      end

      if (enable && (pcnt_q >= PCNT_BLANK)) begin
         segPre = lzMask[idx_q] ? SEG_BLANK : lutSeg;
         dpPre  = dispDp_q[idx_q];
         digPre = NUM_DIGITS'(1) << idx_q;
      end

      seg_d  = (SEG_ACTIVE_LOW != 0) ? ~segPre : segPre;
      dp_d   = (SEG_ACTIVE_LOW != 0) ? ~dpPre  : dpPre;
      dig_d  = (DIG_ACTIVE_LOW != 0) ? ~digPre : digPre;
      tick_d = boundary;
   end

   // State and output registers; reset drops any pending value and parks
   // every pin at its inactive level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pcnt_q      <= '0;
         idx_q       <= '0;
         shadowVal_q <= '0;
         shadowDp_q  <= '0;
         pending_q   <= 1'b0;
         dispVal_q   <= '0;
         dispDp_q    <= '0;
         seg_q       <= SEG_OFF;
         dp_q        <= DP_OFF;
         dig_q       <= DIG_OFF;
         tick_q      <= 1'b0;
      end else begin
         pcnt_q      <= pcnt_d;
         idx_q       <= idx_d;
         shadowVal_q <= shadowVal_d;
         shadowDp_q  <= shadowDp_d;
         pending_q   <= pending_d;
         dispVal_q   <= dispVal_d;
         dispDp_q    <= dispDp_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         dig_q       <= dig_d;
         tick_q      <= tick_d;
      end
   end

   assign segments   = seg_q;
   assign dp_out     = dp_q;
   assign digit_en   = dig_q;
   assign frame_tick = tick_q;
   assign pending    = pending_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// tb_seg7_mux_driver
// Drives two driver instances from the same stimulus: one with active-high
// pins and one with both segment and digit pins inverted. A frame-position
// model predicts every pin each cycle; directed steps add literal checks.
module tb_seg7_mux_driver;

   localparam int N = 4;
   localparam int P = 4;
   localparam int B = 1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           enable = 1'b0;
   logic           load = 1'b0;
   logic [4*N-1:0] value = '0;
   logic [N-1:0]   dpIn = '0;
   logic           lz = 1'b0;

   logic [6:0]     segH, segL;
   logic           dpH, dpL, tickH, tickL, pendH, pendL;
   logic [N-1:0]   digH, digL;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg7_mux_driver #(
      .NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B),
      .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
   ) dutH (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
      .dp_in(dpIn), .lz_suppress(lz), .segments(segH), .dp_out(dpH),
      .digit_en(digH), .frame_tick(tickH), .pending(pendH)
   );

   seg7_mux_driver #(
      .NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B),
      .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
   ) dutL (
      .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
      .dp_in(dpIn), .lz_suppress(lz), .segments(segL), .dp_out(dpL),
      .digit_en(digL), .frame_tick(tickL), .pending(pendL)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [6:0] segTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int             pos = 0;
   logic [4*N-1:0] mDispV = '0, mShV = '0;
   logic [N-1:0]   mDispD = '0, mShD = '0;
   logic           mPend = 1'b0;
   logic           modelValid = 1'b0;
   logic [6:0]     eSeg = '0;
   logic           eDp = 1'b0, eTick = 1'b0, ePend = 1'b0;
   logic [N-1:0]   eDig = '0;

   // Expected pins after each edge, from the frame position before that edge.
   always @(posedge clk) begin
      int   slot, off, top;
      logic bnd;
      if (!rst_n) begin
         pos = 0; mDispV = '0; mDispD = '0; mShV = '0; mShD = '0; mPend = 1'b0;
         eSeg = '0; eDp = 1'b0; eDig = '0; eTick = 1'b0;
      end else begin
         slot = pos / P;
         off  = pos % P;
         bnd  = enable && (pos == N*P - 1);
         top  = N - 1;
         if (lz) begin
            top = 0;
            for (int k = 0; k < N; k++)
               if (mDispV[4*k +: 4] != 4'h0 || mDispD[k]) top = k;
         end
         if (enable && off >= B) begin
            eDig = N'(1) << slot;
            eSeg = (slot <= top) ? segTab[mDispV[4*slot +: 4]] : 7'h00;
            eDp  = mDispD[slot];
         end else begin
            eDig = '0; eSeg = '0; eDp = 1'b0;
         end
         eTick = bnd;
         if (bnd && mPend) begin
            mDispV = mShV; mDispD = mShD; mPend = 1'b0;
         end
         if (load) begin
            mShV = value; mShD = dpIn;
            if (!enable || bnd) begin
               mDispV = value; mDispD = dpIn; mPend = 1'b0;
            end else begin
               mPend = 1'b1;
            end
         end
         pos = enable ? (pos + 1) % (N*P) : 0;
      end
      ePend = mPend;
      modelValid = 1'b1;
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      logic [6:0]   invSeg;
      logic [N-1:0] invDig;
      logic         invDp;
      if (modelValid) begin
         invSeg = ~eSeg;
         invDig = ~eDig;
         invDp  = ~eDp;
         checkOutput("H segments", segH, eSeg);
         checkOutput("H dp_out", dpH, eDp);
         checkOutput("H digit_en", digH, eDig);
         checkOutput("H frame_tick", tickH, eTick);
         checkOutput("H pending", pendH, ePend);
         checkOutput("L segments", segL, invSeg);
         checkOutput("L dp_out", dpL, invDp);
         checkOutput("L digit_en", digL, invDig);
         checkOutput("L frame_tick", tickL, eTick);
         checkOutput("L pending", pendL, ePend);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic applyStimulus(input logic [4*N-1:0] v, input logic [N-1:0] d);
      value = v;
      dpIn  = d;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   task automatic waitLit(input int k, output logic [6:0] segs, output logic dpv);
      int           n;
      logic [N-1:0] want;
      want = N'(1) << k;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (digH != want && n < 100);
      if (digH != want) checkOutput("waitLit timeout", digH, want);
      segs = segH;
      dpv  = dpH;
   endtask

   task automatic waitTick();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tickH && n < 100);
      if (!tickH) checkOutput("waitTick timeout", tickH, 1);
   endtask

   initial begin
      logic [6:0] s;
      logic       d;
      int         gap;

      $display("[TB] start");
      repeat (3) @(negedge clk);
      checkOutput("reset H segments", segH, 7'h00);
      checkOutput("reset H digit_en", digH, 4'h0);
      checkOutput("reset pending", pendH, 0);
      checkOutput("reset L segments", segL, 7'h7F);
      checkOutput("reset L digit_en", digL, 4'hF);
      checkOutput("reset L dp_out", dpL, 1);

      // Disabled load commits straight to the display.
      rst_n = 1'b1;
      applyStimulus(16'h12AF, 4'b0000);
      checkOutput("disabled load pending", pendH, 0);
      checkOutput("disabled L segments", segL, 7'h7F);
      checkOutput("disabled L digit_en", digL, 4'hF);
      enable = 1'b1;
      @(negedge clk);
      checkOutput("enable first blank", digH, 4'h0);
      @(negedge clk);
      checkOutput("enable digit0 lit", digH, 4'h1);
      checkOutput("digit0 seg F", segH, 7'h71);
      checkOutput("digit0 L seg", segL, 7'h0E);
      checkOutput("digit0 L digit_en", digL, 4'hE);
      waitLit(1, s, d); checkOutput("digit1 seg A", s, 7'h77);
      waitLit(2, s, d); checkOutput("digit2 seg 2", s, 7'h5B);
      waitLit(3, s, d); checkOutput("digit3 seg 1", s, 7'h06);

      waitTick();
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (!tickH && gap < 100);
      checkOutput("frame period", gap, 16);

      // Tear-free commit.
      waitLit(1, s, d);
      applyStimulus(16'h1111, 4'b0000);
      checkOutput("midframe pending", pendH, 1);
      waitLit(2, s, d); checkOutput("old value kept", s, 7'h5B);
      waitTick();
      checkOutput("pending cleared at tick", pendH, 0);
      waitLit(0, s, d); checkOutput("new digit0", s, 7'h06);

      // Last load wins.
      waitLit(1, s, d);
      applyStimulus(16'h0001, 4'b0000);
      applyStimulus(16'h0002, 4'b0000);
      checkOutput("double load pending", pendH, 1);
      waitTick();
      waitLit(0, s, d); checkOutput("last load wins", s, 7'h5B);

      // Load exactly on the boundary cycle.
      waitTick();
      repeat (15) @(negedge clk);
      applyStimulus(16'h0003, 4'b0000);
      checkOutput("boundary tick", tickH, 1);
      checkOutput("boundary load no pending", pendH, 0);
      waitLit(0, s, d); checkOutput("boundary value", s, 7'h4F);

      // Leading-zero suppression.
      lz = 1'b1;
      applyStimulus(16'h0040, 4'b0000);
      waitTick();
      waitLit(0, s, d); checkOutput("lz 0040 d0", s, 7'h3F);
      waitLit(1, s, d); checkOutput("lz 0040 d1", s, 7'h66);
      waitLit(2, s, d); checkOutput("lz 0040 d2", s, 7'h00);
      waitLit(3, s, d); checkOutput("lz 0040 d3", s, 7'h00);
      applyStimulus(16'h0000, 4'b0000);
      waitTick();
      waitLit(0, s, d); checkOutput("lz zero d0", s, 7'h3F);
      waitLit(1, s, d); checkOutput("lz zero d1", s, 7'h00);
      waitLit(3, s, d); checkOutput("lz zero d3", s, 7'h00);
      applyStimulus(16'h0040, 4'b0100);
      waitTick();
      waitLit(2, s, d);
      checkOutput("lz dp d2 seg", s, 7'h3F);
      checkOutput("lz dp d2 dp", d, 1);
      waitLit(3, s, d); checkOutput("lz dp d3", s, 7'h00);

      // Enable drop and restart.
      enable = 1'b0;
      @(negedge clk);
      checkOutput("disable L segments", segL, 7'h7F);
      checkOutput("disable L digit_en", digL, 4'hF);
      checkOutput("disable L dp_out", dpL, 1);
      checkOutput("disable no tick", tickH, 0);
      enable = 1'b1;
      @(negedge clk);
      checkOutput("restart blank", digH, 4'h0);
      @(negedge clk);
      checkOutput("restart digit0 lit", digH, 4'h1);

      // Reset with a pending value.
      lz = 1'b0;
      waitLit(1, s, d);
      applyStimulus(16'h8888, 4'b0000);
      checkOutput("pre-reset pending", pendH, 1);
      waitLit(2, s, d);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("reset mid H digit_en", digH, 4'h0);
      checkOutput("reset mid H segments", segH, 7'h00);
      checkOutput("reset mid L segments", segL, 7'h7F);
      checkOutput("reset mid pending", pendH, 0);
      waitLit(0, s, d); checkOutput("after reset d0", s, 7'h3F);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
